uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` serializer between two byte requesters. It accepts a byte from the winning requester and issues a one-cycle `send_en` with the byte on `tr_data`, then waits for `done` before granting again. It also holds the serializer's line configuration (`baud_max_cnt`, `parity_sel`, `stop_sel`) and applies host updates only between frames. A watchdog aborts a frame whose `done` never arrives.

## Interface
Parameters:
- `RESET_BAUD`, 16'd10416, reset value of `baud_max_cnt` (100 MHz / 9600).
- `RESET_PARITY`, 2'b00, reset value of `parity_sel`.
- `RESET_STOP`, 1'b0, reset value of `stop_sel`.
- `TIMEOUT_CYCLES`, 20'd200000, WAIT-state watchdog limit, 20-bit; 0 disables the watchdog.

Ports:
- `mclk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_load` in 1: one-cycle pulse; captures the three `cfg_*` inputs into a pending shadow.
- `cfg_baud_max_cnt` in 16: new baud divider value.
- `cfg_parity_sel` in 2: new parity select.
- `cfg_stop_sel` in 1: new stop-bit select.
- `req0_valid` in 1: requester 0 has a byte.
- `req0_data` in 8: requester 0 byte.
- `req0_ready` out 1: requester 0 transfer accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `tx_done` in 1: `done` from `uart_tx`.
- `send_en` out 1: one-cycle start pulse to `uart_tx`.
- `tr_data` out 8: byte to `uart_tx`, registered.
- `baud_max_cnt` out 16: divider value to `uart_tx`, registered.
- `parity_sel` out 2: parity select to `uart_tx`, registered.
- `stop_sel` out 1: stop-bit select to `uart_tx`, registered.
- `busy` out 1: high when the state is not IDLE.
- `grant_id` out 1: requester of the current or most recent frame.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, LAUNCH, WAIT.
- **IDLE**
  - If the pending-config flag is set: copy the shadow to the config outputs, clear the flag, and hold both `readyN` low this cycle.
  - Otherwise, arbitrate between the valid requesters:
    - One valid requester wins.
    - If both are valid, the requester indicated by the round-robin pointer wins.
  - `readyN` is combinational: (state == IDLE) && !pending && (winner == N) && reqN_valid.
  - On transfer: latch the byte into `tr_data`, set `grant_id`, set the pointer to the other requester, and go to LAUNCH.
- **LAUNCH**: `send_en` = 1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- **WAIT**
  - Increment the watchdog counter each cycle.
  - `tx_done` = 1: go to IDLE.
  - Counter reaches `TIMEOUT_CYCLES`-1 without `tx_done` (and `TIMEOUT_CYCLES` != 0): pulse `timeout_err` and go to IDLE.
  - `tx_done` and timeout in the same cycle: done wins, no error.
- `tx_done` is ignored outside WAIT.
- `cfg_load` is accepted in any state and sets the pending flag.
  - A second `cfg_load` before application overwrites the shadow.
  - `cfg_load` in the same cycle as application: the applied value is the old shadow, the new value is captured, and the flag stays set.
- Config outputs never change in LAUNCH or WAIT.
- Reset values:
  - `send_en`, `tr_data`, `busy`, `grant_id`, `timeout_err`, and both `readyN` are 0.
  - Config outputs take the `RESET_*` parameter values.
  - Pointer = 0 (requester 0 first); pending flag = 0; state = IDLE.
- Reset mid-frame abandons the frame and discards pending config.

## Timing
- Byte accepted at cycle N (`readyN` && `validN`): `send_en` is high at N+1 and `busy` is high from N+1.
- `tx_done` sampled at cycle M: IDLE at M+1, so the next accept can occur at M+1 with `send_en` at M+2.
- Minimum spacing between `send_en` pulses is 3 cycles plus the frame length.
- Pending config is applied in the first IDLE cycle and delays the next accept by exactly one cycle.
- `timeout_err` is high for exactly one cycle, the last WAIT cycle; IDLE follows the next cycle.
- `reset` assertion forces all outputs to reset values asynchronously, without waiting for a clock edge.

## Test plan
- **Reset values**: assert `reset`, including mid-WAIT → all outputs at reset values immediately; `baud_max_cnt` = 10416; state IDLE after release.
- **Single request**: `req0_valid`=1, `req0_data`=8'h55 in IDLE → `req0_ready`=1 the same cycle; `send_en` high one cycle next with `tr_data`=8'h55; `busy` stays high until one cycle after `tx_done`.
- **Round-robin**: hold `req0` (8'hA1) and `req1` (8'hB2) valid continuously and return `tx_done` 20 cycles after each `send_en` → `grant_id` sequence 0,1,0,1; `tr_data` sequence A1,B2,A1,B2.
- **Config deferral**: `cfg_load` with baud 5208, parity 2'b01, stop 1 during WAIT → outputs unchanged until the first IDLE cycle; then updated with both `readyN` low that cycle; the next `send_en` occurs with `baud_max_cnt`=5208.
- **Watchdog**: `TIMEOUT_CYCLES`=100 and `tx_done` never asserted → `timeout_err` pulses on the 100th WAIT cycle, then IDLE; the next request is served normally.
- **Done/timeout collision**: `tx_done` asserted on the 100th WAIT cycle → no `timeout_err`, normal return to IDLE.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin front end for a single uart_tx serializer.
// Two byte requesters share the serializer. Each accepted byte becomes one
// send_en pulse, and the next grant waits for done. The line configuration
// is shadowed here and only reaches the serializer between frames. A
// watchdog abandons a frame whose done never arrives.
module uart_tx_sched #(
  parameter logic [15:0] RESET_BAUD     = 16'd10416,
  parameter logic [1:0]  RESET_PARITY   = 2'b00,
  parameter logic        RESET_STOP     = 1'b0,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [15:0] cfg_baud_max_cnt,
  input  logic [1:0]  cfg_parity_sel,
  input  logic        cfg_stop_sel,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        tx_done,
  output logic        send_en,
  output logic [7:0]  tr_data,
  output logic [15:0] baud_max_cnt,
  output logic [1:0]  parity_sel,
  output logic        stop_sel,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        rr_ptr;       // requester that wins when both are valid
  logic        pending;      // shadow holds config not yet applied
  logic [15:0] shadow_baud;
  logic [1:0]  shadow_parity;
  logic        shadow_stop;
  logic [19:0] wd_cnt;

  logic        winner;
  logic        idle_open;
  logic        accept;
  logic        apply_cfg;
  logic        wd_hit;

  // Arbitration, handshake and the config-apply slot, all from current state.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    winner     = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = rr_ptr;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
    idle_open  = (state == S_IDLE) && !pending;
    req0_ready = idle_open && !winner && req0_valid;
    req1_ready = idle_open &&  winner && req1_valid;
    accept     = req0_ready || req1_ready;
    // A frame boundary with pending config spends this IDLE cycle on the
    // update, which is why both readies are held low above.
    apply_cfg  = (state == S_IDLE) && pending;
    wd_hit     = (TIMEOUT_CYCLES != 20'd0) &&
                 (wd_cnt == TIMEOUT_CYCLES - 20'd1);
  end

  // State register.
  always_ff @(posedge mclk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state strobes; done wins over a same-cycle timeout.
  always_comb begin
    state_next  = state;
    send_en     = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        send_en    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          state_next = S_IDLE;
        end else if (wd_hit) begin
          timeout_err = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

  // Byte capture, grant bookkeeping and round-robin pointer update.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      tr_data  <= 8'h00;
      grant_id <= 1'b0;
      rr_ptr   <= 1'b0;
    end else if (accept) begin
      tr_data  <= req1_ready ? req1_data : req0_data;
      grant_id <= req1_ready;
      rr_ptr   <= req0_ready;   // the other requester gets the next tie
    end
  end

  // Watchdog: cleared while launching, counts every WAIT cycle.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wd_cnt <= 20'd0;
    end else if (state == S_LAUNCH) begin
      wd_cnt <= 20'd0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + 20'd1;
    end
  end

  // Config shadow: capture on cfg_load anytime, copy out only in IDLE.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      pending       <= 1'b0;
      shadow_baud   <= RESET_BAUD;
      shadow_parity <= RESET_PARITY;
      shadow_stop   <= RESET_STOP;
      baud_max_cnt  <= RESET_BAUD;
      parity_sel    <= RESET_PARITY;
      stop_sel      <= RESET_STOP;
    end else begin
      if (cfg_load) begin
        shadow_baud   <= cfg_baud_max_cnt;
        shadow_parity <= cfg_parity_sel;
        shadow_stop   <= cfg_stop_sel;
      end
      // The outputs take the pre-edge shadow, so a load landing in the apply
      // cycle is kept for the next boundary and the flag stays set.
      if (apply_cfg) begin
        baud_max_cnt <= shadow_baud;
        parity_sel   <= shadow_parity;
        stop_sel     <= shadow_stop;
      end
      pending <= cfg_load || (pending && !apply_cfg);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset (incl. mid-frame), single request,
// round-robin, deferred config, watchdog and done/timeout collision.
module tb_uart_tx_sched;

  logic        mclk;
  logic        reset;
  logic        cfg_load;
  logic [15:0] cfg_baud_max_cnt;
  logic [1:0]  cfg_parity_sel;
  logic        cfg_stop_sel;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        tx_done;
  logic        send_en;
  logic [7:0]  tr_data;
  logic [15:0] baud_max_cnt;
  logic [1:0]  parity_sel;
  logic        stop_sel;
  logic        busy;
  logic        grant_id;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_sched #(
    .RESET_BAUD     (16'd10416),
    .RESET_PARITY   (2'b00),
    .RESET_STOP     (1'b0),
    .TIMEOUT_CYCLES (20'd100)
  ) dut (
    .mclk             (mclk),
    .reset            (reset),
    .cfg_load         (cfg_load),
    .cfg_baud_max_cnt (cfg_baud_max_cnt),
    .cfg_parity_sel   (cfg_parity_sel),
    .cfg_stop_sel     (cfg_stop_sel),
    .req0_valid       (req0_valid),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .tx_done          (tx_done),
    .send_en          (send_en),
    .tr_data          (tr_data),
    .baud_max_cnt     (baud_max_cnt),
    .parity_sel       (parity_sel),
    .stop_sel         (stop_sel),
    .busy             (busy),
    .grant_id         (grant_id),
    .timeout_err      (timeout_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  logic exp_id;
  logic seen;

  initial begin
    reset            = 1'b1;
    cfg_load         = 1'b0;
    cfg_baud_max_cnt = 16'd0;
    cfg_parity_sel   = 2'b00;
    cfg_stop_sel     = 1'b0;
    req0_valid       = 1'b0;
    req0_data        = 8'h00;
    req1_valid       = 1'b0;
    req1_data        = 8'h00;
    tx_done          = 1'b0;

    // Reset values
    #2;
    check("rst_send_en", send_en, 0);
    check("rst_tr_data", tr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_baud", baud_max_cnt, 16'd10416);
    check("rst_parity", parity_sel, 0);
    check("rst_stop", stop_sel, 0);
    #21 reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Single request
    req0_valid = 1'b1;
    req0_data  = 8'h55;
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("single_send", send_en, 1);
    check("single_data", tr_data, 8'h55);
    check("single_busy", busy, 1);
    check("single_grant", grant_id, 0);
    tick();
    check("single_send_one", send_en, 0);
    check("single_busy_wait", busy, 1);
    repeat (3) tick();
    tx_done = 1'b1;
    #1;
    check("single_busy_done", busy, 1);
    tick();
    tx_done = 1'b0;
    #1;
    check("single_idle", busy, 0);

    // Reset mid-WAIT with pending config
    req0_valid = 1'b1;
    req0_data  = 8'h99;
    tick();
    req0_valid = 1'b0;
    tick();
    cfg_load         = 1'b1;
    cfg_baud_max_cnt = 16'd1234;
    cfg_parity_sel   = 2'b10;
    cfg_stop_sel     = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("mid_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_send", send_en, 0);
    check("mid_rst_data", tr_data, 0);
    check("mid_rst_baud", baud_max_cnt, 16'd10416);
    #3 reset = 1'b0;
    tick();
    req0_valid = 1'b1;
    #1;
    check("mid_no_pending", req0_ready, 1);
    req0_valid = 1'b0;
    tick();
    check("mid_no_launch", send_en, 0);
    check("mid_baud_kept", baud_max_cnt, 16'd10416);

    // Round-robin, both requesters held valid
    req0_data  = 8'hA1;
    req1_data  = 8'hB2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    exp_id     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready0", req0_ready, !exp_id);
      check("rr_ready1", req1_ready, exp_id);
      tick();
      check("rr_send", send_en, 1);
      check("rr_data", tr_data, exp_id ? 8'hB2 : 8'hA1);
      check("rr_grant", grant_id, exp_id);
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      repeat (20) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      exp_id  = ~exp_id;
    end
    #1;
    check("rr_end_idle", busy, 0);

    // Config deferral
    req1_valid = 1'b1;
    req1_data  = 8'h3C;
    #1;
    check("cfg_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    check("cfg_send", send_en, 1);
    tick();
    cfg_load         = 1'b1;
    cfg_baud_max_cnt = 16'd5208;
    cfg_parity_sel   = 2'b01;
    cfg_stop_sel     = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("cfg_wait_baud", baud_max_cnt, 16'd10416);
    check("cfg_wait_parity", parity_sel, 0);
    check("cfg_wait_stop", stop_sel, 0);
    req0_valid = 1'b1;
    req0_data  = 8'h77;
    #1;
    check("cfg_wait_ready0", req0_ready, 0);
    repeat (2) tick();
    check("cfg_wait_baud2", baud_max_cnt, 16'd10416);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
    check("cfg_apply_busy", busy, 0);
    check("cfg_apply_ready0", req0_ready, 0);
    check("cfg_apply_ready1", req1_ready, 0);
    check("cfg_apply_baud_old", baud_max_cnt, 16'd10416);
    tick();
    check("cfg_new_baud", baud_max_cnt, 16'd5208);
    check("cfg_new_parity", parity_sel, 2'b01);
    check("cfg_new_stop", stop_sel, 1);
    check("cfg_next_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("cfg_next_send", send_en, 1);
    check("cfg_next_data", tr_data, 8'h77);
    check("cfg_next_baud", baud_max_cnt, 16'd5208);
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // Watchdog
    req1_valid = 1'b1;
    req1_data  = 8'hE5;
    tick();
    req1_valid = 1'b0;
    check("wd_send", send_en, 1);
    check("wd_data", tr_data, 8'hE5);
    check("wd_grant", grant_id, 1);
    tick();
    seen = 1'b0;
    repeat (98) begin
      if (timeout_err) seen = 1'b1;
      tick();
    end
    if (timeout_err) seen = 1'b1;
    tick();
    check("wd_no_early", seen, 0);
    check("wd_pulse", timeout_err, 1);
    check("wd_busy_last", busy, 1);
    tick();
    check("wd_pulse_end", timeout_err, 0);
    check("wd_idle", busy, 0);
    req0_valid = 1'b1;
    req0_data  = 8'h12;
    #1;
    check("wd_after_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("wd_after_send", send_en, 1);
    check("wd_after_data", tr_data, 8'h12);

    // Done/timeout collision on the 100th WAIT cycle
    tick();
    repeat (99) tick();
    tx_done = 1'b1;
    #1;
    check("col_no_err", timeout_err, 0);
    check("col_busy", busy, 1);
    tick();
    tx_done = 1'b0;
    #1;
    check("col_idle", busy, 0);
    check("col_no_err_after", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
